// File: rtl/dmem_responder.sv
// Data-memory responder: serialized valid/ready load/store access to a word array with a fixed access latency.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned halfword/word accesses return rsp_err instead of being aligned down.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);
   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t         state_reg;
   logic [3:0]     cnt_reg;
   logic           we_reg;
   logic [AW+1:0]  addr_reg;
   logic [31:0]    wdata_reg;
   logic [2:0]     funct3_reg;
   logic           ready_reg;
   logic           valid_reg;
   logic           err_reg;

   logic [31:0]    raw_word;
   logic           f3_ok;
   logic           access_err;
   logic           commit;
   logic [1:0]     offset;
   logic [3:0]     byte_en;
   logic [31:0]    wr_word;
   logic [7:0]     sel_byte;
   logic [15:0]    sel_half;
   logic [31:0]    load_word;
   logic           addr_unused;

   // Upper address bits fold away: the array wraps modulo its byte size.
   assign addr_unused = ^req_addr[31:AW+2];

   assign commit = (state_reg == ACCESS) && (cnt_reg == 4'd0) && reset;

   always_comb begin
      case (funct3_reg)
         3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
         3'b100, 3'b101:         f3_ok = !we_reg;
         default:                f3_ok = 1'b0;
      endcase
`ifdef DMEM_MISALIGN_TRAP_EN
      access_err = !f3_ok
                 || (funct3_reg[1:0] == 2'b01 && addr_reg[0])
                 || (funct3_reg[1:0] == 2'b10 && addr_reg[1:0] != 2'b00);
`else
      access_err = !f3_ok;
`endif
      // Effective lane offset; misaligned halfword/word offsets are forced down.
      case (funct3_reg[1:0])
         2'b00:   offset = addr_reg[1:0];
         2'b01:   offset = {addr_reg[1], 1'b0};
         default: offset = 2'b00;
      endcase
      wr_word = wdata_reg;
      case (funct3_reg[1:0])
         2'b00: begin
            byte_en = 4'b0001 << offset;
            wr_word = {4{wdata_reg[7:0]}};
         end
         2'b01: begin
            byte_en = offset[1] ? 4'b1100 : 4'b0011;
            wr_word = {2{wdata_reg[15:0]}};
         end
         2'b10:   byte_en = 4'b1111;
         default: byte_en = 4'b0000;
      endcase
      if (access_err || !we_reg) begin
         byte_en = 4'b0000;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH_WORDS];
         logic [7:0] rd_byte_reg;
         always_ff @(posedge clk) begin
            if (commit) begin
               if (byte_en[gi]) begin
                  lane_mem[addr_reg[AW+1:2]] <= wr_word[8*gi +: 8];
               end
               rd_byte_reg <= lane_mem[addr_reg[AW+1:2]];
            end
         end
         assign raw_word[8*gi +: 8] = rd_byte_reg;
      end
   endgenerate

   always_comb begin
      sel_byte = raw_word[{offset, 3'b000} +: 8];
      sel_half = offset[1] ? raw_word[31:16] : raw_word[15:0];
      case (funct3_reg[1:0])
         2'b00:   load_word = {{24{sel_byte[7] & !funct3_reg[2]}}, sel_byte};
         2'b01:   load_word = {{16{sel_half[15] & !funct3_reg[2]}}, sel_half};
         default: load_word = raw_word;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg  <= IDLE;
         cnt_reg    <= 4'd0;
         ready_reg  <= 1'b0;
         valid_reg  <= 1'b0;
         err_reg    <= 1'b0;
         we_reg     <= 1'b0;
         addr_reg   <= '0;
         wdata_reg  <= 32'd0;
         funct3_reg <= 3'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               ready_reg <= 1'b1;
               if (req_valid && ready_reg) begin
                  we_reg     <= req_we;
                  addr_reg   <= req_addr[AW+1:0];
                  wdata_reg  <= req_wdata;
                  funct3_reg <= req_funct3;
                  cnt_reg    <= 4'(LATENCY - 1);
                  ready_reg  <= 1'b0;
                  state_reg  <= ACCESS;
               end
            end
            ACCESS: begin
               if (cnt_reg == 4'd0) begin
                  state_reg <= RESP;
                  valid_reg <= 1'b1;
                  err_reg   <= access_err;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state_reg <= IDLE;
                  valid_reg <= 1'b0;
                  err_reg   <= 1'b0;
                  ready_reg <= 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign req_ready = ready_reg;
   assign rsp_valid = valid_reg;
   assign rsp_err   = err_reg;
   assign rsp_rdata = (valid_reg && !err_reg && !we_reg) ? load_word : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed test-plan steps then random traffic against a byte-array model.
module tb_dmem_responder;
   localparam int DEPTH = 1024;
   localparam int LAT   = 2;
   localparam int MEMB  = 4 * DEPTH;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic [2:0]  req_funct3 = 3'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int total = 0;
   int bad   = 0;
   logic [7:0] mb [MEMB];

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference behaviour: bytes in a flat array, sizes and sign rules straight from funct3.
   task automatic model_access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                               input logic [2:0] f3, output logic [31:0] rd, output logic err);
      int unsigned base;
      int sz;
      logic [31:0] v;
      base = a % MEMB;
      err = 1'b0;
      rd  = 32'd0;
      sz  = 1;
      case (f3)
         3'd0: sz = 1;
         3'd1: sz = 2;
         3'd2: sz = 4;
         3'd4: begin sz = 1; err = we; end
         3'd5: begin sz = 2; err = we; end
         default: err = 1'b1;
      endcase
`ifdef DMEM_MISALIGN_TRAP_EN
      if (base % sz != 0) err = 1'b1;
`else
      base = base - (base % sz);
`endif
      if (!err) begin
         if (we) begin
            for (int i = 0; i < sz; i++) mb[base + i] = wd[8*i +: 8];
         end else begin
            v = 32'd0;
            for (int i = 0; i < sz; i++) v = v | (32'(mb[base + i]) << (8*i));
            if (sz < 4 && !f3[2] && v[8*sz-1]) v = v | ~((32'd1 << (8*sz)) - 32'd1);
            rd = v;
         end
      end
   endtask

   task automatic send(input bit we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, input bit early,
                       output logic [31:0] ord, output logic oerr);
      logic [31:0] erd;
      logic eerr;
      int k;
      @(negedge clk);
      chk("req_ready_idle", req_ready, 32'd1);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3;
      rsp_ready = early;
      @(posedge clk);
      model_access(we, a, wd, f3, erd, eerr);
      k = 0;
      do begin
         @(negedge clk);
         req_valid = 1'b0;
         req_addr = $urandom;
         req_wdata = $urandom;
         req_funct3 = 3'($urandom);
         k++;
         chk("req_ready_busy", req_ready, 32'd0);
      end while (rsp_valid !== 1'b1 && k < 20);
      chk("latency", k, LAT + 1);
      ord  = rsp_rdata;
      oerr = rsp_err;
      chk("rdata", ord, erd);
      chk("err", oerr, eerr);
      $display("txn we=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
               we, f3, a, wd, ord, oerr, k);
   endtask

   task automatic complete(input int hold);
      logic [31:0] held;
      held = rsp_rdata;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", rsp_valid, 32'd1);
         chk("hold_rdata", rsp_rdata, held);
         chk("hold_ready", req_ready, 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("post_valid", rsp_valid, 32'd0);
      chk("post_ready", req_ready, 32'd1);
      rsp_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] rd, w0, a, wd;
      logic er;
      bit we, early;
      logic [2:0] f3;
      for (int i = 0; i < MEMB; i++) mb[i] = 8'h00;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_ready", req_ready, 32'd0);
      chk("rst_valid", rsp_valid, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", rsp_err, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("rel_ready", req_ready, 32'd1);

      // Known contents for the region random traffic touches
      for (int i = 0; i < 16; i++) begin
         send(1'b1, 32'(4*i), $urandom, 3'b010, 1'(i % 2), rd, er);
         complete(0);
      end

      send(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b0, rd, er); complete(0);
      send(1'b0, 32'h10, 32'd0, 3'b010, 1'b0, rd, er);        complete(0);
      chk("lw10", rd, 32'hDEADBEEF);
      chk("lw10_err", er, 32'd0);
      send(1'b1, 32'h11, 32'h0000007F, 3'b000, 1'b1, rd, er); complete(0);
      send(1'b0, 32'h10, 32'd0, 3'b010, 1'b1, rd, er); complete(0);
      chk("lw10_sb", rd, 32'hDEAD7FEF);
      send(1'b0, 32'h13, 32'd0, 3'b000, 1'b0, rd, er); complete(0);
      chk("lb13", rd, 32'hFFFFFFDE);
      send(1'b0, 32'h13, 32'd0, 3'b100, 1'b0, rd, er); complete(0);
      chk("lbu13", rd, 32'h000000DE);
      send(1'b0, 32'h12, 32'd0, 3'b001, 1'b0, rd, er); complete(0);
      chk("lh12", rd, 32'hFFFFDEAD);
      send(1'b0, 32'h12, 32'd0, 3'b101, 1'b0, rd, er); complete(0);
      chk("lhu12", rd, 32'h0000DEAD);

      // Back-pressure: response held five cycles
      send(1'b0, 32'h10, 32'd0, 3'b010, 1'b0, rd, er);
      complete(5);

      // Reset during ACCESS discards the store
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0; req_wdata = 32'h12345678; req_funct3 = 3'b010;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("abort_valid", rsp_valid, 32'd0);
      chk("abort_ready", req_ready, 32'd0);
      @(negedge clk);
      chk("abort_ready_rel", req_ready, 32'd1);
      send(1'b0, 32'h0, 32'd0, 3'b010, 1'b0, rd, er); complete(0);
      w0 = rd;
      $display("txn abort check: word0=%h", w0);

      // Misaligned word load
      send(1'b0, 32'h2, 32'd0, 3'b010, 1'b0, rd, er); complete(0);
`ifdef DMEM_MISALIGN_TRAP_EN
      chk("lw2_err", er, 32'd1);
      chk("lw2_rdata", rd, 32'd0);
`else
      chk("lw2_err", er, 32'd0);
      chk("lw2_rdata", rd, w0);
`endif

      // Illegal funct3 and address wrap
      send(1'b0, 32'h4, 32'd0, 3'b011, 1'b0, rd, er); complete(0);
      chk("ill_load_err", er, 32'd1);
      send(1'b1, 32'h4, 32'hA5A5A5A5, 3'b100, 1'b0, rd, er); complete(0);
      chk("ill_store_err", er, 32'd1);
      send(1'b1, 32'(4*DEPTH + 8), 32'hCAFEF00D, 3'b010, 1'b0, rd, er); complete(0);
      send(1'b0, 32'h8, 32'd0, 3'b010, 1'b0, rd, er); complete(0);
      chk("wrap_lw8", rd, 32'hCAFEF00D);

      // Reset during RESP drops the response
      send(1'b0, 32'h4, 32'd0, 3'b111, 1'b0, rd, er);
      reset = 1'b0;
      @(negedge clk);
      chk("rresp_valid", rsp_valid, 32'd0);
      chk("rresp_err", rsp_err, 32'd0);
      chk("rresp_rdata", rsp_rdata, 32'd0);
      chk("rresp_ready", req_ready, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("rresp_ready_rel", req_ready, 32'd1);

      // Random traffic in the low 64 bytes, with random upper (wrapping) address bits
      for (int t = 0; t < 80; t++) begin
         we    = 1'($urandom_range(0, 1));
         f3    = 3'($urandom_range(0, 7));
         a     = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
         wd    = $urandom;
         early = 1'($urandom_range(0, 1));
         send(we, a, wd, f3, early, rd, er);
         complete(early ? 0 : $urandom_range(0, 2));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
